conv_psum_accum: RTL and testbench
==================================

// Module: conv_psum_accum
// PURPOSE
//  Downstream of the conv input window buffer and its MAC array: accumulates per-lane 32-bit products
//  over all kernel taps (x input channels) of one output channel.
//  Adds bias, rounds Q16.16->Q8.8, saturates to 16 bits, optionally applies ReLU.
//  Presents one output row-tile with a valid/ready handshake to the pooling/writeback stage.
// PARAMETERS
//  LANES  112  MAC lanes (= `MAC_NUM); SCONV_1 uses all 112, SCONV_2 uses lanes 0..99
//  DW     16   activation/bias width, Q8.8 signed
//  PW     32   product width, Q16.16 signed
//  AW     40   accumulator width; no overflow for num_taps<=255 by construction
//  FRAC   8    fractional bits removed on output
// PORTS
//  clk        in   1          clock
//  rst_n      in   1          async active-low reset
//  cur_state  in   4          layer state (`SCONV_1/`SCONV_2 active; others -> lane mask all-zero)
//  clr        in   1          sync abort: counters cleared, state->IDLE, out_valid dropped
//  num_taps   in   8          beats per tile (25 SCONV_1, 150 SCONV_2); sampled on first beat
//  bias_in    in   DW         per-output-channel bias, Q8.8; sampled on first beat
//  relu_en    in   1          clamp negatives to 0; sampled on first beat
//  prod_valid in   1          product beat valid
//  prod_ready out  1          accumulator can accept a beat
//  prod_in    in   LANES*PW   lane products, lane i at [i*PW +: PW]
//  out_valid  out  1          out_data holds a finished tile
//  out_ready  in   1          consumer accepts tile
//  out_data   out  LANES*DW   lane results, lane i at [i*DW +: DW]; masked lanes = 0
// BEHAVIOUR
//  Reset (async): state IDLE, tap_cnt=0, acc=0, out_valid=0, out_data=0, prod_ready=0.
//    prod_ready rises on the first edge after rst_n deasserts.
//  Beat accepted = prod_valid & prod_ready at a rising edge.
//  FSM:
//  - IDLE: prod_ready=1. On a beat: acc=sext(prod), latch num_taps/bias/relu_en, tap_cnt=1.
//    Then ->FIN if num_taps==1, else ->ACC.
//  - ACC: prod_ready=1. On a beat: acc+=sext(prod), tap_cnt++.
//    On the beat with tap_cnt==num_taps-1 ->FIN. No beat: hold.
//  - FIN: prod_ready=0. One cycle:
//    r = (acc + (bias<<FRAC) + (1<<(FRAC-1))) >>> FRAC (round half up).
//    Saturate r to [-32768, 32767]; if relu_en and r<0 then 0.
//    Register into out_data; out_valid=1; ->OUT.
//  - OUT: prod_ready=0. out_data/out_valid held stable until out_valid&out_ready, then out_valid=0 ->IDLE.
//  Latency: last beat accepted at edge t -> out_valid=1 from edge t+1.
//    Minimum back-to-back spacing is 2 idle cycles (FIN, OUT with out_ready=1).
//  num_taps==0 sampled: treated as 1.
//  clr has priority over beats and the handshake in every state.
//    A beat coincident with clr is dropped; a completing handshake coincident with clr is lost to the consumer.
//  Beats presented while prod_ready=0 are ignored (not buffered); upstream must hold.
//  Lane mask: cur_state==`SCONV_2 -> lanes 100..111 forced 0. cur_state not SCONV -> all lanes 0.
//  Async reset mid-tile discards the partial sum; no output is produced.
// STRUCTURE
//  def_header.vh: `MAC_NUM, `SCONV_1/`SCONV_2/`SFC_x state codes, FSM state encodings
//    (IDLE/ACC/FIN/OUT), Q-format FRAC constant.
//  Sub-module acc_lane:
//  - Ports: one lane's PW->AW accumulate with load/add select, plus the combinational round/saturate/ReLU.
//  - Generated LANES times.
//  - The parent holds the FSM, tap counter, sampled config and mask.
// TESTING
//  1. SCONV_1, num_taps=25, all prod=65536 (1.0*1.0), bias=256, relu=0
//     -> out_valid 1 edge after beat 25; every lane out=6656 (26.0).
//  2. num_taps=1, prod=+128 then separate tile prod=-128, bias=0
//     -> outputs 1 then 0 (round half up); prod=-384 -> -1.
//  3. SCONV_2, 150 beats prod=0x3FFF0000, bias=0 -> lanes 0..99 = 32767, lanes 100..111 = 0.
//     Repeat with prod negative: relu=0 -> -32768, relu=1 -> 0.
//  4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, prod_ready=0,
//     beats presented are ignored. Next tile result is unaffected by them.
//  5. prod_valid toggled pseudo-randomly across 25 taps with lane i product = i*256
//     -> out lane i = 25*i (saturated at 32767), tap count exact.
//  6. clr at beat 10, and rst_n pulsed low at beat 12 of a fresh tile -> no out_valid.
//     Outputs 0 after reset; the following clean tile matches scenario 1.

Source files
------------

// File: rtl/conv_psum_accum_pkg.sv
// Shared constants for the conv partial-sum accumulator: layer state codes,
// MAC lane count, Q-format fraction width and the accumulator FSM encoding.
package conv_psum_accum_pkg;

    localparam int MAC_NUM       = 112;
    localparam int SCONV_2_LANES = 100;
    localparam int Q_FRAC        = 8;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] SCONV_1 = 4'd1;
    localparam logic [3:0] SCONV_2 = 4'd2;
    localparam logic [3:0] SFC_1   = 4'd3;
    localparam logic [3:0] SFC_2   = 4'd4;
    localparam logic [3:0] SFC_3   = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_FIN  = 2'd2,
        ST_OUT  = 2'd3
    } acc_state_t;

    // Which MAC lanes carry real data for a given layer state.
    function automatic logic lane_active(input logic [3:0] layer, input int lane);
        logic on;
        on = 1'b0;
        if (layer == SCONV_1) begin
            on = (lane < MAC_NUM);
        end else if (layer == SCONV_2) begin
            on = (lane < SCONV_2_LANES);
        end
        return on;
    endfunction

endpackage

// File: rtl/conv_psum_accum_acc_lane.sv
// One MAC lane: sign-extending PW->AW accumulator with load/add select, plus
// the combinational bias add, round-half-up, saturate and ReLU to a Q8.8 result.
module acc_lane
    import conv_psum_accum_pkg::*;
#(
    parameter int DW   = 16,
    parameter int PW   = 32,
    parameter int AW   = 40,
    parameter int FRAC = Q_FRAC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 add,
    input  logic signed [PW-1:0] prod,
    input  logic signed [DW-1:0] bias,
    input  logic                 relu_en,
    output logic        [DW-1:0] res
);

    localparam logic signed [AW-1:0] RND    = AW'(1) << (FRAC - 1);
    localparam logic signed [AW-1:0] SAT_HI = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] bias_ext;
    logic signed [AW-1:0] rnd_sum;
    logic signed [AW-1:0] shifted;

    assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    // Bias is Q8.8; align it to the Q16.16 accumulator before adding.
    assign bias_ext = {{(AW-DW-FRAC){bias[DW-1]}}, bias, {FRAC{1'b0}}};
    assign rnd_sum  = acc + bias_ext + RND;
    assign shifted  = rnd_sum >>> FRAC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (load) begin
            acc <= prod_ext;
        end else if (add) begin
            acc <= acc + prod_ext;
        end
    end

    always_comb begin
        res = shifted[DW-1:0];
        if (shifted > SAT_HI) begin
            res = SAT_HI[DW-1:0];
        end else if (shifted < SAT_LO) begin
            res = SAT_LO[DW-1:0];
        end
        if (relu_en && res[DW-1]) begin
            res = '0;
        end
    end

endmodule

// File: rtl/conv_psum_accum.sv
// Per-lane partial-sum accumulator for one output channel: sums num_taps product
// beats, finishes to Q8.8 and offers the row-tile to the writeback stage.
module conv_psum_accum
    import conv_psum_accum_pkg::*;
#(
    parameter int LANES = MAC_NUM,
    parameter int DW    = 16,
    parameter int PW    = 32,
    parameter int AW    = 40,
    parameter int FRAC  = Q_FRAC
) (
    input  logic                [3:0] cur_state,
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                [7:0] num_taps,
    input  logic signed      [DW-1:0] bias_in,
    input  logic                      relu_en,
    input  logic                      prod_valid,
    output logic                      prod_ready,
    input  logic       [LANES*PW-1:0] prod_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic       [LANES*DW-1:0] out_data,
    output logic                [1:0] dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid, once raised, holds its payload until that edge.

    acc_state_t state;
    acc_state_t state_nx;

    logic              [7:0] tap_cnt;
    logic              [7:0] taps_q;
    logic              [7:0] taps_eff;
    logic signed  [DW-1:0]   bias_q;
    logic                    relu_q;
    logic                    beat;
    logic                    lane_load;
    logic                    lane_add;
    logic                    fin_cap;
    logic                    out_take;
    logic          [DW-1:0]  lane_res [LANES];
    logic       [LANES-1:0]  lane_on;

    assign beat      = prod_valid & prod_ready;
    assign out_take  = out_valid & out_ready;
    assign taps_eff  = (num_taps == 8'd0) ? 8'd1 : num_taps;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (beat) state_nx = (taps_eff == 8'd1) ? ST_FIN : ST_ACC;
                ST_ACC:  if (beat && (tap_cnt == taps_q - 8'd1)) state_nx = ST_FIN;
                ST_FIN:  state_nx = ST_OUT;
                ST_OUT:  if (out_take) state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        lane_load = 1'b0;
        lane_add  = 1'b0;
        fin_cap   = 1'b0;
        if (!clr) begin
            lane_load = beat && (state == ST_IDLE);
            lane_add  = beat && (state == ST_ACC);
            fin_cap   = (state == ST_FIN);
        end
    end

    // Registered from the next state so ready stays low through the reset edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_ready <= 1'b0;
        end else begin
            prod_ready <= (state_nx == ST_IDLE) || (state_nx == ST_ACC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt <= '0;
            taps_q  <= 8'd1;
            bias_q  <= '0;
            relu_q  <= 1'b0;
        end else if (clr) begin
            tap_cnt <= '0;
        end else if (lane_load) begin
            tap_cnt <= 8'd1;
            taps_q  <= taps_eff;
            bias_q  <= bias_in;
            relu_q  <= relu_en;
        end else if (lane_add) begin
            tap_cnt <= tap_cnt + 8'd1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        acc_lane #(
            .DW   (DW),
            .PW   (PW),
            .AW   (AW),
            .FRAC (FRAC)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .load    (lane_load),
            .add     (lane_add),
            .prod    (prod_in[i*PW +: PW]),
            .bias    (bias_q),
            .relu_en (relu_q),
            .res     (lane_res[i])
        );
        assign lane_on[i] = lane_active(cur_state, i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else if (fin_cap) begin
            out_valid <= 1'b1;
            for (int i = 0; i < LANES; i++) begin
                out_data[i*DW +: DW] <= lane_on[i] ? lane_res[i] : '0;
            end
        end else if (out_take) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_psum_accum.sv
// Directed and randomized bench for conv_psum_accum with a per-lane integer
// reference model and an expected-result queue.
module tb_conv_psum_accum;
  import conv_psum_accum_pkg::*;

  localparam int LANES = 112;
  localparam int DW    = 16;
  localparam int PW    = 32;
  localparam int PB    = LANES * PW;
  localparam int OB    = LANES * DW;

  logic          clk;
  logic          rst_n;
  logic [3:0]    cur_state;
  logic          clr;
  logic [7:0]    num_taps;
  logic [DW-1:0] bias_in;
  logic          relu_en;
  logic          prod_valid;
  logic          prod_ready;
  logic [PB-1:0] prod_in;
  logic          out_valid;
  logic          out_ready;
  logic [OB-1:0] out_data;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  longint        model_sum [LANES];
  int            model_bias;
  bit            model_relu;
  logic [3:0]    model_layer;
  logic [OB-1:0] exp_q [$];

  conv_psum_accum dut (
    .cur_state  (cur_state),
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .num_taps   (num_taps),
    .bias_in    (bias_in),
    .relu_en    (relu_en),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_in    (prod_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic logic [DW-1:0] lane_model(input longint s, input int bias, input bit relu);
    longint r;
    r = (s + longint'(bias) * 256 + 128) >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r[DW-1:0];
  endfunction

  function automatic bit lane_used(input logic [3:0] layer, input int i);
    if (layer == SCONV_1) return 1'b1;
    if (layer == SCONV_2) return (i < 100);
    return 1'b0;
  endfunction

  function automatic logic [OB-1:0] model_result();
    logic [OB-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      if (lane_used(model_layer, i)) r[i*DW +: DW] = lane_model(model_sum[i], model_bias, model_relu);
    return r;
  endfunction

  function automatic logic [PB-1:0] uniform_prod(input logic [31:0] v);
    logic [PB-1:0] p;
    for (int i = 0; i < LANES; i++) p[i*PW +: PW] = v;
    return p;
  endfunction

  function automatic logic [PB-1:0] ramp_prod();
    logic [PB-1:0] p;
    for (int i = 0; i < LANES; i++) p[i*PW +: PW] = 32'(i * 256);
    return p;
  endfunction

  function automatic logic [PB-1:0] random_prod();
    logic [PB-1:0] p;
    for (int i = 0; i < LANES; i++) p[i*PW +: PW] = $urandom;
    return p;
  endfunction

  // checks
  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic [OB-1:0] exp);
    int bad;
    checks++;
    assert (out_data === exp) else begin
      failures++;
      bad = 0;
      for (int i = LANES - 1; i >= 0; i--)
        if (out_data[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
      $error("FAIL %s lane=%0d observed=%h expected=%h", tag, bad,
             out_data[bad*DW +: DW], exp[bad*DW +: DW]);
    end
  endtask

  // drivers
  task automatic start_tile(input logic [3:0] layer, input logic [7:0] taps,
                            input logic [DW-1:0] bias, input bit relu);
    @(negedge clk);
    cur_state = layer;
    num_taps  = taps;
    bias_in   = bias;
    relu_en   = relu;
    model_layer = layer;
    model_bias  = int'($signed(bias));
    model_relu  = relu;
    for (int i = 0; i < LANES; i++) model_sum[i] = 0;
  endtask

  task automatic beat(input logic [PB-1:0] p, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      prod_valid = 1'b0;
    end
    @(negedge clk);
    prod_valid = 1'b1;
    prod_in    = p;
    n = 0;
    while (prod_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (prod_ready !== 1'b1) begin
      checks++;
      failures++;
      $error("FAIL beat_timeout observed=%0b expected=1", prod_ready);
    end
    @(posedge clk);
    for (int i = 0; i < LANES; i++) model_sum[i] += longint'($signed(p[i*PW +: PW]));
  endtask

  task automatic end_tile();
    @(negedge clk);
    prod_valid = 1'b0;
    exp_q.push_back(model_result());
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic collect(input string tag);
    int n;
    logic [OB-1:0] exp;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1({tag, "_valid"}, out_valid, 1'b1);
    exp = exp_q.pop_front();
    check_bus(tag, exp);
    handshake();
    check1({tag, "_drop"}, out_valid, 1'b0);
  endtask

  task automatic run_tile(input string tag, input logic [3:0] layer, input int taps,
                          input logic [DW-1:0] bias, input bit relu,
                          input logic [PB-1:0] p, input int max_gap);
    start_tile(layer, 8'(taps), bias, relu);
    for (int b = 0; b < taps; b++) beat(p, $urandom_range(0, max_gap));
    end_tile();
    collect(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    prod_valid = 1'b0;
    rst_n = 1'b0;
    #3;
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_prod_ready", prod_ready, 1'b0);
    check1("rst_out_data_zero", out_data == '0, 1'b1);
    check1("rst_state_idle", dbg_state == ST_IDLE, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check1("rst_ready_low_at_release", prod_ready, 1'b0);
    @(negedge clk);
    check1("rst_ready_after_edge", prod_ready, 1'b1);
  endtask

  initial begin
    int hi;
    logic [OB-1:0] exp;
    rst_n      = 1'b1;
    cur_state  = SCONV_1;
    clr        = 1'b0;
    num_taps   = 8'd25;
    bias_in    = '0;
    relu_en    = 1'b0;
    prod_valid = 1'b0;
    prod_in    = '0;
    out_ready  = 1'b0;
    #1;
    do_reset();

    // 1: 25 taps of 1.0*1.0 plus bias 1.0, with latency check
    start_tile(SCONV_1, 8'd25, 16'd256, 1'b0);
    for (int b = 0; b < 25; b++) beat(uniform_prod(32'd65536), 0);
    end_tile();
    check1("s1_valid_not_yet", out_valid, 1'b0);
    check1("s1_ready_low_fin", prod_ready, 1'b0);
    @(negedge clk);
    check1("s1_valid_next_edge", out_valid, 1'b1);
    exp = '0;
    for (int i = 0; i < LANES; i++) exp[i*DW +: DW] = 16'd6656;
    check_bus("s1_const_6656", exp);
    void'(exp_q.pop_front());
    exp = model_result();
    check_bus("s1_model", exp);
    handshake();
    check1("s1_drop", out_valid, 1'b0);
    check1("s1_ready_back", prod_ready, 1'b1);

    // 2: single-tap rounding, and num_taps=0 treated as 1
    run_tile("s2_pos128", SCONV_1, 1, 16'd0, 1'b0, uniform_prod(32'd128), 0);
    run_tile("s2_neg128", SCONV_1, 1, 16'd0, 1'b0, uniform_prod(-32'sd128), 0);
    run_tile("s2_neg384", SCONV_1, 1, 16'd0, 1'b0, uniform_prod(-32'sd384), 0);
    start_tile(SCONV_1, 8'd0, 16'd0, 1'b0);
    beat(uniform_prod(32'd768), 0);
    end_tile();
    collect("s2_taps0");

    // 3: SCONV_2 saturation and lane masking
    run_tile("s3_sat_pos", SCONV_2, 150, 16'd0, 1'b0, uniform_prod(32'h3FFF0000), 0);
    run_tile("s3_sat_neg", SCONV_2, 150, 16'd0, 1'b0, uniform_prod(32'hC0010000), 0);
    run_tile("s3_sat_relu", SCONV_2, 150, 16'd0, 1'b1, uniform_prod(32'hC0010000), 0);
    run_tile("s3_non_sconv", SFC_1, 4, 16'd300, 1'b0, uniform_prod(32'd70000), 0);

    // 4: backpressure with ignored beats
    start_tile(SCONV_1, 8'd3, 16'hFF00, 1'b0);
    for (int b = 0; b < 3; b++) beat(uniform_prod(32'd50000), 0);
    end_tile();
    @(negedge clk);
    exp = exp_q.pop_front();
    hi = 0;
    prod_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      prod_in = random_prod();
      @(negedge clk);
      if (out_valid !== 1'b1 || prod_ready !== 1'b0 || out_data !== exp) hi++;
    end
    check1("s4_hold_stable", hi == 0, 1'b1);
    check_bus("s4_data", exp);
    prod_valid = 1'b0;
    handshake();
    check1("s4_drop", out_valid, 1'b0);
    run_tile("s4_next", SCONV_1, 3, 16'd10, 1'b0, uniform_prod(32'd1000), 1);

    // 5: gappy valid, ramp products, exact tap count
    start_tile(SCONV_1, 8'd25, 16'd0, 1'b0);
    for (int b = 0; b < 24; b++) beat(ramp_prod(), $urandom_range(0, 3));
    @(negedge clk);
    prod_valid = 1'b0;
    repeat (4) @(negedge clk);
    check1("s5_no_early_valid", out_valid, 1'b0);
    check1("s5_still_ready", prod_ready, 1'b1);
    beat(ramp_prod(), $urandom_range(0, 3));
    end_tile();
    exp = '0;
    for (int i = 0; i < LANES; i++) exp[i*DW +: DW] = 16'(25 * i);
    check1("s5_model_matches_ramp", exp_q[0] == exp, 1'b1);
    collect("s5_ramp");

    // random tiles against the model
    for (int t = 0; t < 6; t++) begin
      start_tile(($urandom_range(0, 1) == 0) ? SCONV_1 : SCONV_2, 8'($urandom_range(1, 6)),
                 16'($urandom), 1'($urandom_range(0, 1)));
      for (int b = 0; b < int'(num_taps); b++) beat(random_prod(), $urandom_range(0, 2));
      end_tile();
      collect($sformatf("rand_%0d", t));
    end

    // 6: clr mid-tile, then reset mid-tile, then clean tile
    start_tile(SCONV_1, 8'd25, 16'd256, 1'b0);
    for (int b = 0; b < 9; b++) beat(uniform_prod(32'd65536), 0);
    @(negedge clk);
    prod_in = uniform_prod(32'd65536);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    prod_valid = 1'b0;
    hi = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) hi++;
    end
    check1("s6_clr_no_valid", hi == 0, 1'b1);
    run_tile("s6_after_clr", SCONV_1, 25, 16'd256, 1'b0, uniform_prod(32'd65536), 0);
    start_tile(SCONV_1, 8'd25, 16'd256, 1'b0);
    for (int b = 0; b < 11; b++) beat(uniform_prod(32'd65536), 0);
    do_reset();
    hi = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) hi++;
    end
    check1("s6_rst_no_valid", hi == 0, 1'b1);
    run_tile("s6_clean", SCONV_1, 25, 16'd256, 1'b0, uniform_prod(32'd65536), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
